// File: rtl/nmcu_main_mem_if.sv
// Shared memory-path types and the request/response bundle between a requester
// and the simulated main memory.
package nmcu_pkg;
  localparam int MEM_SIZE_WORDS = 16384;
  localparam int MEM_LATENCY    = 5;

  typedef struct packed {
    logic        valid;
    logic        write_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  len;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic        hit;
    logic [31:0] addr;
    logic [31:0] rdata;
  } mem_resp_t;
endpackage

interface nmcu_main_mem_if;
  import nmcu_pkg::*;

  mem_req_t  req_i;
  logic      req_ready;
  mem_resp_t resp_o;
  logic      busy;

  modport master (output req_i, input req_ready, input resp_o, input busy);
  modport slave  (input req_i, output req_ready, output resp_o, output busy);
endinterface

// File: rtl/nmcu_main_mem.sv
// Word-organised main memory model with fixed response latency, burst reads and
// burst writes; one request in flight at a time.
module nmcu_main_mem
  import nmcu_pkg::*;
#(
  parameter int DEPTH   = MEM_SIZE_WORDS,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  nmcu_main_mem_if.slave  bus
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WBURST, WAIT, RBURST} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [IDXW-1:0] r_baseIdx;
  logic [7:0]      r_len;
  logic [7:0]      r_beat;
  logic [CNTW-1:0] r_cnt;
  logic            r_isWrite;
  logic            r_ackDone;
  mem_resp_t       r_resp;

  // Contents survive rst; only the time-zero value is defined.
  logic [31:0]     r_mem [DEPTH] = '{default: '0};

  logic            w_ready;
  logic            w_accept;
  logic [IDXW-1:0] w_reqIdx;
  logic [7:0]      w_reqLen;
  logic [IDXW-1:0] w_beatIdx;
  logic            w_latDone;
  logic            w_wrLast;
  logic            w_rdLast;
  logic            w_memWe;
  logic [IDXW-1:0] w_memIdx;
  logic            w_unused;

  assign w_ready   = (r_state == IDLE) || (r_state == WBURST);
  assign w_accept  = bus.req_i.valid && w_ready;
  assign w_reqIdx  = bus.req_i.addr[IDXW+1:2];
  assign w_reqLen  = (bus.req_i.len == 8'd0) ? 8'd1 : bus.req_i.len;
  assign w_beatIdx = r_baseIdx + IDXW'(r_beat);
  assign w_latDone = (r_cnt == '0);
  assign w_wrLast  = (r_beat == r_len - 8'd1);
  assign w_rdLast  = (r_beat == r_len);
  assign w_memWe   = w_accept && ((r_state == WBURST) ||
                                  ((r_state == IDLE) && bus.req_i.write_en));
  assign w_memIdx  = (r_state == WBURST) ? w_beatIdx : w_reqIdx;
  assign w_unused  = ^{bus.req_i.addr[31:IDXW+2], bus.req_i.addr[1:0]};

  assign bus.req_ready = w_ready;
  assign bus.busy      = (r_state != IDLE);
  assign bus.resp_o    = r_resp;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // A write stays in WAIT for one extra cycle so its ack beat is never seen while IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.req_i.write_en && (w_reqLen != 8'd1)) w_nextState = WBURST;
          else                                          w_nextState = WAIT;
        end
      end
      WBURST: begin
        if (w_accept && w_wrLast) w_nextState = WAIT;
      end
      WAIT: begin
        if (w_latDone) begin
          if (!r_isWrite)     w_nextState = RBURST;
          else if (r_ackDone) w_nextState = IDLE;
        end
      end
      RBURST: begin
        if (w_rdLast) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baseIdx <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_cnt     <= '0;
      r_isWrite <= 1'b0;
      r_ackDone <= 1'b0;
      r_resp    <= '0;
    end else begin
      r_resp <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_baseIdx <= w_reqIdx;
            r_len     <= w_reqLen;
            r_isWrite <= bus.req_i.write_en;
            r_ackDone <= 1'b0;
            r_beat    <= bus.req_i.write_en ? 8'd1 : 8'd0;
            r_cnt     <= CNTW'(LATENCY - 1);
          end
        end
        WBURST: begin
          if (w_accept) begin
            r_beat <= r_beat + 8'd1;
            r_cnt  <= CNTW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (!w_latDone) begin
            r_cnt <= r_cnt - CNTW'(1);
          end else if (r_isWrite) begin
            if (!r_ackDone) begin
              r_ackDone    <= 1'b1;
              r_resp.valid <= 1'b1;
              r_resp.addr  <= 32'({r_baseIdx, 2'b00});
            end
          end else begin
            r_resp.valid <= 1'b1;
            r_resp.addr  <= 32'({w_beatIdx, 2'b00});
            r_resp.rdata <= r_mem[w_beatIdx];
            r_beat       <= r_beat + 8'd1;
          end
        end
        RBURST: begin
          if (!w_rdLast) begin
            r_resp.valid <= 1'b1;
            r_resp.addr  <= 32'({w_beatIdx, 2'b00});
            r_resp.rdata <= r_mem[w_beatIdx];
            r_beat       <= r_beat + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_memWe) r_mem[w_memIdx] <= bus.req_i.wdata;
  end

endmodule
